// File: rtl/muldiv_seq_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_seq_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic            req_valid;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [4:0]      req_rd;
    logic            stall;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;

    modport master (
        output flush, req_valid, req_op, req_a, req_b, req_rd,
        input  stall, resp_valid, resp_data, resp_rd
    );

    modport slave (
        input  flush, req_valid, req_op, req_a, req_b, req_rd,
        output stall, resp_valid, resp_data, resp_rd
    );
endinterface

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplier for MUL/MULH/MULHSU/MULHU.
module muldiv_seq_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    muldiv_seq_unit_if.slave io_bus
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [2:0]          r_op, w_op;
    logic [4:0]          r_rd, w_rd;
    logic [XLEN-1:0]     r_a, w_a, r_b, w_b, r_res, w_res;
    logic [2*XLEN-1:0]   r_acc, w_acc;
    logic                r_neg_q, w_neg_q, r_neg_r, w_neg_r;

    logic                w_a_sgn, w_b_sgn, w_sa, w_sb, w_div_zero, w_div_ovf;
    logic [XLEN-1:0]     w_abs_a, w_abs_b, w_quot, w_rem, w_final;
    logic [XLEN:0]       w_mul_sum, w_div_trial;
    logic [2*XLEN-1:0]   w_step, w_prod;

    // Operand signedness per funct3; only MULHSU mixes signed a with unsigned b
    always_comb begin
        w_a_sgn = 1'b1;
        w_b_sgn = 1'b1;
        case (io_bus.req_op)
            3'b010:                 w_b_sgn = 1'b0;
            3'b011, 3'b101, 3'b111: begin
                w_a_sgn = 1'b0;
                w_b_sgn = 1'b0;
            end
            default: ;
        endcase
    end

    assign w_sa       = w_a_sgn & io_bus.req_a[XLEN-1];
    assign w_sb       = w_b_sgn & io_bus.req_b[XLEN-1];
    assign w_abs_a    = w_sa ? -io_bus.req_a : io_bus.req_a;
    assign w_abs_b    = w_sb ? -io_bus.req_b : io_bus.req_b;
    assign w_div_zero = io_bus.req_op[2] && (io_bus.req_b == '0);
    assign w_div_ovf  = (io_bus.req_op == 3'b100 || io_bus.req_op == 3'b110)
                        && (io_bus.req_a == {1'b1, {(XLEN-1){1'b0}}}) && (io_bus.req_b == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_ext_a, w_ext_b, w_fast_prod;
    assign w_ext_a     = {{XLEN{w_sa}}, io_bus.req_a};
    assign w_ext_b     = {{XLEN{w_sb}}, io_bus.req_b};
    assign w_fast_prod = w_ext_a * w_ext_b;
`endif

    // One iteration: acc = {hi, lo}; multiply shifts right, divide shifts left
    assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};

    always_comb begin
        if (!r_op[2]) begin
            w_step = {w_mul_sum, r_acc[XLEN-1:1]};
        end else if (!w_div_trial[XLEN]) begin
            w_step = {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_step = {r_acc[2*XLEN-2:0], 1'b0};
        end
    end

    assign w_prod = r_neg_q ? -w_step : w_step;
    assign w_quot = r_neg_q ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
    assign w_rem  = r_neg_r ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];

    always_comb begin
        if (r_op[2]) begin
            w_final = r_op[1] ? w_rem : w_quot;
        end else if (r_op[1:0] == 2'b00) begin
            w_final = w_prod[XLEN-1:0];
        end else begin
            w_final = w_prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_op    = r_op;
        w_rd    = r_rd;
        w_a     = r_a;
        w_b     = r_b;
        w_acc   = r_acc;
        w_res   = r_res;
        w_neg_q = r_neg_q;
        w_neg_r = r_neg_r;
        unique case (r_state)
            StIdle: begin
                if (io_bus.req_valid && !io_bus.flush) begin
                    w_op    = io_bus.req_op;
                    w_rd    = io_bus.req_rd;
                    w_a     = w_abs_a;
                    w_b     = w_abs_b;
                    w_neg_q = w_sa ^ w_sb;
                    w_neg_r = w_sa;
                    w_cnt   = '0;
                    w_acc   = {{XLEN{1'b0}}, (io_bus.req_op[2] ? w_abs_a : w_abs_b)};
                    if (w_div_zero) begin
                        w_res   = io_bus.req_op[1] ? io_bus.req_a : '1;
                        w_state = StDone;
                    end else if (w_div_ovf) begin
                        w_res   = io_bus.req_op[1] ? '0 : io_bus.req_a;
                        w_state = StDone;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!io_bus.req_op[2]) begin
                        w_res   = (io_bus.req_op[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0]
                                                                : w_fast_prod[2*XLEN-1:XLEN];
                        w_state = StDone;
                    end
`endif
                    else begin
                        w_state = StBusy;
                    end
                end
            end
            StBusy: begin
                w_acc = w_step;
                w_cnt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(XLEN - 1)) begin
                    w_res   = w_final;
                    w_state = StDone;
                end
            end
            StDone:  w_state = StIdle;
            default: w_state = StIdle;
        endcase
        if (io_bus.flush) begin
            w_state = StIdle;
            w_cnt   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_op    <= '0;
            r_rd    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_res   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_op    <= w_op;
            r_rd    <= w_rd;
            r_a     <= w_a;
            r_b     <= w_b;
            r_acc   <= w_acc;
            r_res   <= w_res;
            r_neg_q <= w_neg_q;
            r_neg_r <= w_neg_r;
        end
    end

    assign io_bus.stall      = io_bus.req_valid && (r_state != StDone) && !io_bus.flush;
    assign io_bus.resp_valid = (r_state == StDone) && !io_bus.flush;
    assign io_bus.resp_data  = r_res;
    assign io_bus.resp_rd    = r_rd;
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit: latency, results, early-outs, flush, reset, back-to-back.
module tb_muldiv_seq_unit;
    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 33;
`endif
    localparam int DivLat = 33;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cycle;

    muldiv_seq_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_seq_unit #(.XLEN(XLEN)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Drives one request from the current low phase and waits for its response.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] data, output logic [4:0] rd_o,
                          output int lat, output int nstall, output logic after_v,
                          output int at_cycle);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_rd    = rd;
        lat = -1; nstall = 0; data = '0; rd_o = '0; after_v = 1'b0; at_cycle = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.resp_valid) begin
                lat = i; data = bus.resp_data; rd_o = bus.resp_rd; at_cycle = cycle;
                break;
            end
            if (bus.stall) nstall++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        after_v = bus.resp_valid;
    endtask

    task automatic check_op(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                            input int exp_lat);
        logic [31:0] d; logic [4:0] r; int lat, ns, at; logic av;
        run_op(op, a, b, rd, d, r, lat, ns, av, at);
        n_checks += 4;
        if (lat !== exp_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d exp %0d", name, lat, exp_lat);
        end
        if (ns !== exp_lat) begin
            n_fail++; $display("FAIL %s stall cycles: got %0d exp %0d", name, ns, exp_lat);
        end
        if (d !== exp || r !== rd) begin
            n_fail++; $display("FAIL %s data/rd: got %h/%0d exp %h/%0d", name, d, r, exp, rd);
        end
        if (av !== 1'b0) begin
            n_fail++; $display("FAIL %s resp_valid width: got %b after strobe exp 0", name, av);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.flush = 0; bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0;
        bus.req_rd = 0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_data !== '0 || bus.resp_rd !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got %b %h %0d exp 0 0 0",
                     bus.resp_valid, bus.resp_data, bus.resp_rd);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mul;
        check_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MulLat);
        check_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, MulLat);
        check_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, MulLat);
        check_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, MulLat);
    endtask

    task automatic test_div;
        check_op("div", 3'b100, 32'hFFFF_FFEC, 32'd3, 5'd10, 32'hFFFF_FFFA, DivLat);
        check_op("rem", 3'b110, 32'hFFFF_FFEC, 32'd3, 5'd11, 32'hFFFF_FFFE, DivLat);
        check_op("divu", 3'b101, 32'd100, 32'd7, 5'd12, 32'd14, DivLat);
        check_op("remu", 3'b111, 32'd100, 32'd7, 5'd13, 32'd2, DivLat);
    endtask

    task automatic test_early_out;
        check_op("div_by0", 3'b100, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1);
        check_op("rem_by0", 3'b110, 32'd5, 32'd0, 5'd15, 32'd5, 1);
        check_op("divu_by0", 3'b101, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF, 1);
        check_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1);
        check_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, 1);
    endtask

    task automatic test_flush;
        int seen;
        bus.req_valid = 1'b1; bus.req_op = 3'b101; bus.req_a = 32'd1000; bus.req_b = 32'd7;
        bus.req_rd = 5'd9;
        repeat (11) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush gating: got stall=%b resp_valid=%b exp 0 0",
                     bus.stall, bus.resp_valid);
        end
        @(negedge clk);
        bus.flush = 1'b0; bus.req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.resp_valid || bus.stall) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL flush no-resp: got %0d active cycles exp 0", seen);
        end
        // Flush at cnt 10, then a new MUL in the very next cycle must be captured
        #1;
        bus.req_valid = 1'b1; bus.req_op = 3'b101; bus.req_a = 32'd1000; bus.req_b = 32'd7;
        repeat (11) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check_op("mul_after_flush", 3'b000, 32'd12, 32'd11, 5'd19, 32'd132, MulLat);
    endtask

    task automatic test_rst_mid;
        int seen;
        bus.req_valid = 1'b1; bus.req_op = 3'b101; bus.req_a = 32'd500; bus.req_b = 32'd3;
        bus.req_rd = 5'd20;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_data !== '0 || bus.resp_rd !== '0) begin
            n_fail++;
            $display("FAIL reset mid-op: got %b %h %0d exp 0 0 0",
                     bus.resp_valid, bus.resp_data, bus.resp_rd);
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus.resp_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL reset residual resp: got %0d strobes exp 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d1, d2; logic [4:0] r1, r2; int l1, l2, s1, s2, c1, c2; logic a1, a2;
        run_op(3'b101, 32'd100, 32'd7, 5'd3, d1, r1, l1, s1, a1, c1);
        run_op(3'b101, 32'd81, 32'd9, 5'd4, d2, r2, l2, s2, a2, c2);
        n_checks += 3;
        if (d1 !== 32'd14 || r1 !== 5'd3) begin
            n_fail++; $display("FAIL b2b first: got %0d/%0d exp 14/3", d1, r1);
        end
        if (d2 !== 32'd9 || r2 !== 5'd4) begin
            n_fail++; $display("FAIL b2b second: got %0d/%0d exp 9/4", d2, r2);
        end
        if (c2 - c1 !== DivLat + 1) begin
            n_fail++; $display("FAIL b2b spacing: got %0d exp %0d", c2 - c1, DivLat + 1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cycle    = 0;
        test_reset();
        test_mul();
        test_div();
        test_early_out();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
